// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one byte-stream requester at a time access to a
// UART transmit FIFO, with forced release on packet overrun or stalled owner.

module uart_tx_arbiter_lane (
   input  logic       gnt,
   input  logic       valid,
   input  logic       tx_full,
   input  logic [7:0] data,
   output logic       ready,
   output logic       xfer,
   output logic [7:0] data_sel
);
   assign ready    = gnt & ~tx_full;
   assign xfer     = ready & valid;
   assign data_sel = data & {8{gnt}};
endmodule

module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int MAX_PKT = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*8-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   input  logic              tx_full,
   output logic              wr_uart,
   output logic [7:0]        w_data,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              timeout_err,
   output logic              overflow_err
);
   localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [IW-1:0]       gidx_q, gidx_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [7:0]          byte_cnt_q, byte_cnt_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic                terr_q, terr_d, oerr_q, oerr_d;

   logic [NREQ-1:0]       lane_ready, lane_xfer;
   logic [NREQ-1:0][7:0]  lane_data;

   // Grant is all-zero outside XFER, so the lanes alone gate every output.
   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      uart_tx_arbiter_lane u_lane (
         .gnt      (grant_q[i]),
         .valid    (req_valid[i]),
         .tx_full  (tx_full),
         .data     (req_data[i*8 +: 8]),
         .ready    (lane_ready[i]),
         .xfer     (lane_xfer[i]),
         .data_sel (lane_data[i])
      );
   end

   assign req_ready    = lane_ready;
   assign wr_uart      = |lane_xfer;
   assign grant        = grant_q;
   assign busy         = (state_q == XFER);
   assign timeout_err  = terr_q;
   assign overflow_err = oerr_q;

   always_comb begin
      w_data = '0;
      for (int i = 0; i < NREQ; i++) w_data = w_data | lane_data[i];
   end

   // Scan downward in offset so the requester nearest ptr wins.
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [IW:0]   cand;
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (req_valid[cand[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   logic release_pkt;
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      ptr_d       = ptr_q;
      byte_cnt_d  = byte_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      terr_d      = 1'b0;
      oerr_d      = 1'b0;
      release_pkt = 1'b0;
      case (state_q)
         IDLE: begin
            byte_cnt_d = '0;
            idle_cnt_d = '0;
            if (pick_found) begin
               state_d           = XFER;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               gidx_d            = pick_idx;
            end
         end
         XFER: begin
            if (wr_uart) begin
               byte_cnt_d = byte_cnt_q + 8'd1;
               idle_cnt_d = '0;
               if (req_last[gidx_q]) begin
                  release_pkt = 1'b1;
               end else if (byte_cnt_q + 8'd1 == 8'(MAX_PKT)) begin
                  release_pkt = 1'b1;
                  oerr_d      = 1'b1;
               end
            end else if (!req_valid[gidx_q]) begin
               // A stalled owner counts toward timeout; a full FIFO does not.
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               if (idle_cnt_q + IDLE_W'(1) == IDLE_W'(TIMEOUT)) begin
                  release_pkt = 1'b1;
                  terr_d      = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (release_pkt) begin
         state_d = IDLE;
         grant_d = '0;
         ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         ptr_q      <= '0;
         byte_cnt_q <= '0;
         idle_cnt_q <= '0;
         terr_q     <= 1'b0;
         oerr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         ptr_q      <= ptr_d;
         byte_cnt_q <= byte_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         terr_q     <= terr_d;
         oerr_q     <= oerr_d;
      end
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter MAX_PKT, default 16, maximum bytes per granted packet.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, cycles a grant may stay with no valid byte before forced release.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester byte valid.
REQ-007 The block SHALL have port req_data  input  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 The block SHALL have port req_last  input  NREQ  marks final byte of a packet; qualified by req_valid.
REQ-009 The block SHALL have port req_ready  output  NREQ  per-requester byte accept.
REQ-010 The block SHALL have port tx_full  input  1  UART transmit FIFO full flag.
REQ-011 The block SHALL have port wr_uart  output  1  UART transmit FIFO write strobe.
REQ-012 The block SHALL have port w_data  output  8  byte to UART transmit FIFO.
REQ-013 The block SHALL have port grant  output  NREQ  registered one-hot owner of the UART; all-zero when idle.
REQ-014 The block SHALL have port busy  output  1  high while in state XFER.
REQ-015 The block SHALL have port timeout_err  output  1  one-cycle pulse on forced release by TIMEOUT.
REQ-016 The block SHALL have port overflow_err  output  1  one-cycle pulse on forced release by MAX_PKT.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and XFER.
REQ-018 In IDLE with any req_valid high, the block SHALL choose the first requester with req_valid set, searching upward from round-robin pointer ptr with wrap at NREQ, register its one-hot grant, and enter XFER on the next edge (1-cycle arbitration latency).
REQ-019 In IDLE, req_ready, wr_uart and grant SHALL be 0, and no byte SHALL be transferred.
REQ-020 In XFER, req_ready[g] SHALL equal ~tx_full combinationally for granted index g; all other req_ready bits SHALL be 0.
REQ-021 A byte transfer SHALL occur in any XFER cycle with req_valid[g]=1 and tx_full=0; in that cycle wr_uart SHALL be 1 and w_data SHALL equal req_data[g] combinationally.
REQ-022 Outside a transfer cycle, wr_uart SHALL be 0, and w_data SHALL be don't-care but stable at req_data[g] while granted.
REQ-023 An 8-bit byte counter SHALL clear on entry to XFER and increment on each transfer.
REQ-024 A transfer with req_last[g]=1 SHALL end the packet: the next state SHALL be IDLE, grant SHALL clear, and ptr SHALL become (g+1) mod NREQ.
REQ-025 The transfer that makes the byte count equal MAX_PKT without req_last SHALL force release exactly as in REQ-024 and SHALL pulse overflow_err in the following cycle.
REQ-026 An idle counter SHALL increment in XFER cycles with req_valid[g]=0, and SHALL clear on any transfer and on entry to XFER.
REQ-027 Cycles with req_valid[g]=1 and tx_full=1 SHALL not advance the idle counter; a full UART FIFO SHALL never cause a timeout.
REQ-028 When the idle counter reaches TIMEOUT, the block SHALL release as in REQ-024 and pulse timeout_err in the following cycle.
REQ-029 A release and a new arbitration SHALL never occur in the same cycle; IDLE SHALL always last at least one cycle between packets.
REQ-030 Requests from non-granted requesters SHALL be held pending without loss; the arbiter SHALL not drop or reorder bytes within a packet.
REQ-031 If MAX_PKT and req_last coincide on the same byte, the block SHALL treat it as normal completion with no overflow_err.

Reset
REQ-032 When reset is asserted, the block SHALL immediately place state in IDLE, grant=0, ptr=0, both counters=0, busy=0, timeout_err=0 and overflow_err=0, and SHALL force wr_uart=0 and req_ready=0.
REQ-033 Reset asserted mid-packet SHALL abort the packet without a further wr_uart, and arbitration after deassertion SHALL restart from requester 0.

Verification
REQ-034 Scenario: after reset, req_valid=4'b0110 held -> grant=4'b0010 one cycle later, then 4'b0100 after req 1's last byte and one IDLE cycle.
REQ-035 Scenario: req 0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, tx_full=0 -> exactly 3 wr_uart pulses, w_data in order, grant cleared the cycle after 0x43.
REQ-036 Scenario: tx_full=1 for 300 cycles while req 2 is granted and valid -> no wr_uart, no timeout_err; bytes resume on tx_full=0.
REQ-037 Scenario: granted req 3 drops req_valid for 255 cycles -> one timeout_err pulse, grant=0, next arbitration starts at req 0.
REQ-038 Scenario: req 1 sends 20 bytes with no last, MAX_PKT=16 -> 16 wr_uart pulses, then overflow_err pulse; the remaining 4 bytes are sent under a new grant.
REQ-039 Scenario: reset asserted after 2 of 5 bytes -> wr_uart=0 immediately, grant=0, no further bytes until re-arbitration.
